// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem request,
// buffers returned words in a 2-entry FIFO and applies redirects with flush/kill.
//
//   state | meaning
//   IDLE  | no request outstanding; waits for buffer space
//   REQ   | request for pc outstanding on imem
//   KILL  | redirected while a request was in flight; drain and drop its response
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        misalign_o
);

   localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

   state_t      state, state_next;
   logic [31:0] pc;
   logic [31:0] kill_addr;
   logic [1:0]  count;
   logic [1:0]  cnt_pop;
   logic [1:0]  cnt_next;
   logic        pop;
   logic        push;
   logic        space;
   logic [31:0] e0_pc, e0_instr, e1_pc, e1_instr;
   logic [31:0] target;

   assign target   = {redirect_pc_i[31:2], 2'b00};
   assign if_valid = (count != 2'd0);
   assign if_pc    = e0_pc;
   assign if_instr = e0_instr;

   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      imem_addr  = pc;
      pop        = if_valid & ~stall_i & ~redirect_i;
      push       = (state == REQ) & imem_ready & ~redirect_i;
      cnt_pop    = count - {1'b0, pop};
      cnt_next   = cnt_pop + {1'b0, push};
      space      = (cnt_pop < FULL);
      case (state)
         IDLE: begin
            if (!redirect_i && space) state_next = REQ;
         end
         REQ: begin
            imem_req = 1'b1;
            if (redirect_i)      state_next = imem_ready ? IDLE : KILL;
            else if (imem_ready) state_next = (cnt_next < FULL) ? REQ : IDLE;
         end
         KILL: begin
            // the memory still owns the old request, so keep presenting its address
            imem_req  = 1'b1;
            imem_addr = kill_addr;
            if (imem_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         kill_addr  <= 32'd0;
         count      <= 2'd0;
         e0_pc      <= 32'd0;
         e0_instr   <= 32'd0;
         e1_pc      <= 32'd0;
         e1_instr   <= 32'd0;
         misalign_o <= 1'b0;
      end else begin
         state      <= state_next;
         misalign_o <= redirect_i & (redirect_pc_i[1:0] != 2'b00);
         if (redirect_i)  pc <= target;
         else if (push)   pc <= pc + 32'd4;
         if ((state == REQ) && redirect_i && !imem_ready) kill_addr <= pc;
         if (redirect_i) begin
            count <= 2'd0;
         end else begin
            count <= cnt_next;
            if (pop) begin
               e0_pc    <= e1_pc;
               e0_instr <= e1_instr;
            end
            // a push lands behind whatever survives the pop; later NBA wins on e0
            if (push) begin
               if (cnt_pop == 2'd0) begin
                  e0_pc    <= pc;
                  e0_instr <= imem_rdata;
               end else begin
                  e1_pc    <= pc;
                  e1_instr <= imem_rdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: transaction-level memory/stream model feeding a
// scoreboard queue, with a separate negedge monitor comparing the IF/ID head.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign_o;
   logic [31:0] key = 32'd0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ key;

   fetch_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .misalign_o    (misalign_o)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] m_pc = 32'h0000_3000;
   logic        kill_pend = 1'b0;
   logic [31:0] kill_addr = 32'd0;
   logic        exp_mis = 1'b0;
   logic        was_reset = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: every accepted memory response that is neither killed nor coincident with
   // a redirect must reach decode in fetch order; a redirect discards everything buffered.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_pc      = 32'h0000_3000;
         kill_pend = 1'b0;
         exp_mis   = 1'b0;
         was_reset = 1'b1;
      end else begin
         was_reset = 1'b0;
         if (imem_req && imem_ready) begin
            chk("imem_addr", imem_addr, kill_pend ? kill_addr : m_pc);
            if (!kill_pend && !redirect_i) begin
               exp_q.push_back({m_pc, m_pc ^ key});
               m_pc += 32'd4;
            end
            kill_pend = 1'b0;
         end else if (imem_req && redirect_i && !kill_pend) begin
            kill_pend = 1'b1;
            kill_addr = m_pc;
         end
         exp_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
         if (redirect_i) begin
            exp_q.delete();
            m_pc = {redirect_pc_i[31:2], 2'b00};
         end
      end
   end

   always @(negedge clk) begin
      if (was_reset) begin
         chk1("rst_if_valid", if_valid, 1'b0);
         chk("rst_if_pc", if_pc, 32'd0);
         chk("rst_if_instr", if_instr, 32'd0);
         chk1("rst_imem_req", imem_req, 1'b0);
         chk1("rst_misalign", misalign_o, 1'b0);
      end else begin
         chk1("if_valid", if_valid, exp_q.size() != 0);
         if (if_valid && exp_q.size() != 0) begin
            chk("if_pc", if_pc, exp_q[0].pc);
            chk("if_instr", if_instr, exp_q[0].instr);
            if (!stall_i && !redirect_i) void'(exp_q.pop_front());
         end
         if (misalign_o || exp_mis) chk1("misalign", misalign_o, exp_mis);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input logic [31:0] exp_pc);
      int n;
      n = 0;
      @(negedge clk);
      while (!if_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk1({name, "_valid"}, if_valid, 1'b1);
      chk({name, "_pc"}, if_pc, exp_pc);
   endtask

   initial begin
      repeat (3) cyc();
      // streaming from reset, rdata == addr
      imem_ready = 1'b1;
      rst_n      = 1'b1;
      @(negedge clk);
      chk1("req_before_first_edge", imem_req, 1'b0);
      @(negedge clk);
      chk1("first_req", imem_req, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk1("stream_valid", if_valid, 1'b1);
         chk("stream_pc", if_pc, 32'h0000_3000 + 32'(4 * k));
      end

      // decode stall fills the buffer and parks the fetcher
      cyc();
      stall_i = 1'b1;
      repeat (3) cyc();
      @(negedge clk);
      chk1("stall_req_low", imem_req, 1'b0);
      chk1("stall_valid", if_valid, 1'b1);
      cyc();
      stall_i = 1'b0;
      repeat (6) cyc();

      // redirect with a full buffer under stall
      stall_i = 1'b1;
      repeat (3) cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_3100;
      cyc();
      redirect_i = 1'b0;
      @(negedge clk);
      chk1("flush_valid", if_valid, 1'b0);
      stall_i = 1'b0;
      wait_valid("redir_target", 32'h0000_3100);

      // misaligned redirect while a request waits for ready
      cyc();
      imem_ready = 1'b0;
      @(negedge clk);
      chk1("pending_req", imem_req, 1'b1);
      cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_3102;
      cyc();
      redirect_i = 1'b0;
      @(negedge clk);
      chk1("misalign_pulse", misalign_o, 1'b1);
      chk1("kill_req_held", imem_req, 1'b1);
      repeat (2) cyc();
      imem_ready = 1'b1;
      wait_valid("after_kill", 32'h0000_3100);

      // reset while a killed request is still outstanding
      cyc();
      imem_ready = 1'b0;
      cyc();
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_5000;
      cyc();
      redirect_i = 1'b0;
      rst_n      = 1'b0;
      key        = 32'hA5C3_1E0F;
      cyc();
      rst_n      = 1'b1;
      imem_ready = 1'b1;
      wait_valid("restart", 32'h0000_3000);

      // randomized traffic, including wrap-around targets and occasional resets
      for (int i = 0; i < 3000; i++) begin
         cyc();
         imem_ready    = ($urandom_range(0, 2) != 0);
         stall_i       = ($urandom_range(0, 3) == 0);
         redirect_i    = !redirect_i && ($urandom_range(0, 11) == 0);
         redirect_pc_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : (32'h0000_4000 | ($urandom & 32'h0FFF));
         rst_n         = (i % 500 != 499);
      end
      cyc();
      redirect_i = 1'b0;
      rst_n      = 1'b1;
      repeat (4) cyc();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
